// File: rtl/alu4_exec_pipe.sv
// Two-stage valid/ready execution pipe around a 4-bit ALU with an accumulator for chained ops.
// Optional sticky carry/overflow flags are enabled by defining ALU4_STICKY_FLAGS_EN.

module alu4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       c,
    output logic       n,
    output logic       z,
    output logic       v
);
    logic [4:0] sum;

    // Logic ops leave carry and overflow at zero; sub is a + ~b + 1, so c=1 means no borrow
    always_comb begin
        sum    = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            3'b000: result = ~a;
            3'b001: result = ~b;
            3'b010: result = a & b;
            3'b011: result = a | b;
            3'b100: result = a ^ b;
            3'b101: result = ~(a ^ b);
            3'b110: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[3:0];
                c      = sum[4];
                v      = (a[3] == b[3]) && (sum[3] != a[3]);
            end
            default: begin
                sum    = {1'b0, a} + {1'b0, ~b} + 5'd1;
                result = sum[3:0];
                c      = sum[4];
                v      = (a[3] != b[3]) && (sum[3] != a[3]);
            end
        endcase
        n = result[3];
        z = (result == 4'h0);
    end
endmodule

module alu4_exec_pipe #(
    parameter int         CNT_W    = 8,
    parameter logic [3:0] ACC_INIT = 4'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_result,
    output logic             out_c,
    output logic             out_n,
    output logic             out_z,
    output logic             out_v,
`ifdef ALU4_STICKY_FLAGS_EN
    input  logic             sticky_clr,
    output logic             sticky_c,
    output logic             sticky_v,
`endif
    output logic [CNT_W-1:0] ops_done
);
    logic       s1_valid;
    logic [3:0] s1_a;
    logic [3:0] s1_b;
    logic [2:0] s1_op;
    logic       s1_acc;
    logic [3:0] acc;
    logic       s2_adv;
    logic       s1_load;
    logic [3:0] a_sel;
    logic [3:0] alu_result;
    logic       alu_c;
    logic       alu_n;
    logic       alu_z;
    logic       alu_v;

    // in_ready depends only on stage state, never on in_valid
    assign s2_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;
    assign s1_load  = in_valid & in_ready;
    assign a_sel    = s1_acc ? acc : s1_a;

    alu4 u_alu (
        .a      (a_sel),
        .b      (s1_b),
        .op     (s1_op),
        .result (alu_result),
        .c      (alu_c),
        .n      (alu_n),
        .z      (alu_z),
        .v      (alu_v)
    );

    // The accumulator is read and written at the same S2 load, so chained ops forward without a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= '0;
            s1_acc     <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_c      <= 1'b0;
            out_n      <= 1'b0;
            out_z      <= 1'b0;
            out_v      <= 1'b0;
            acc        <= ACC_INIT;
            ops_done   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_op    <= in_op;
                s1_acc   <= in_acc;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid  <= 1'b1;
                out_result <= alu_result;
                out_c      <= alu_c;
                out_n      <= alu_n;
                out_z      <= alu_z;
                out_v      <= alu_v;
                acc        <= alu_result;
                ops_done   <= ops_done + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU4_STICKY_FLAGS_EN
    // Only add/sub loads can raise the sticky flags; a clear in the same cycle takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
        end else if (sticky_clr) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
        end else if (s2_adv && (s1_op[2:1] == 2'b11)) begin
            if (alu_c) sticky_c <= 1'b1;
            if (alu_v) sticky_v <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu4_exec_pipe.sv
// Directed self-checking bench for alu4_exec_pipe; sticky-flag checks build only with ALU4_STICKY_FLAGS_EN.

module tb_alu4_exec_pipe;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic       in_acc;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_c;
    logic       out_n;
    logic       out_z;
    logic       out_v;
    logic [7:0] ops_done;
`ifdef ALU4_STICKY_FLAGS_EN
    logic       sticky_clr;
    logic       sticky_c;
    logic       sticky_v;
`endif

    int checks = 0;
    int fails  = 0;

    alu4_exec_pipe #(.CNT_W(8), .ACC_INIT(4'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_n      (out_n),
        .out_z      (out_z),
        .out_v      (out_v),
`ifdef ALU4_STICKY_FLAGS_EN
        .sticky_clr (sticky_clr),
        .sticky_c   (sticky_c),
        .sticky_v   (sticky_v),
`endif
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_acc    = 1'b0;
        reset     = 1'b1;
        #2;
        reset     = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 4'h0;
        in_b      = 4'h0;
        in_op     = 3'b000;
        in_acc    = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL reset_handshake: got valid/ready %b required 01", {out_valid, in_ready});
        end
        checks++;
        if ({out_result, out_c, out_n, out_z, out_v} !== 8'h00 || ops_done !== 8'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got res %h flags %b ops %0d required 0", out_result,
                     {out_c, out_n, out_z, out_v}, ops_done);
        end
        // Fill both stages, then reset mid-flight
        in_valid = 1'b1; in_a = 4'h1; in_b = 4'h1; in_op = 3'b110;
        step();
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ops_done !== 8'd0) begin
            fails++;
            $display("[TB] FAIL midflight_async: got valid %b ops %0d required 0 0", out_valid, ops_done);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || ops_done !== 8'd0) begin
            fails++;
            $display("[TB] FAIL midflight_after: got valid/ready %b ops %0d required 01 0",
                     {out_valid, in_ready}, ops_done);
        end
    endtask

    task automatic test_arith();
        logic [2:0] v_op [6] = '{3'b110, 3'b111, 3'b111, 3'b110, 3'b110, 3'b111};
        logic [3:0] v_a  [6] = '{4'h7, 4'h5, 4'h3, 4'h9, 4'hF, 4'h8};
        logic [3:0] v_b  [6] = '{4'h1, 4'h5, 4'h5, 4'h8, 4'h1, 4'h1};
        logic [3:0] v_r  [6] = '{4'h8, 4'h0, 4'hE, 4'h1, 4'h0, 4'h7};
        logic [3:0] v_f  [6] = '{4'b0101, 4'b1010, 4'b0100, 4'b1001, 4'b1010, 4'b1001};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_acc = 1'b0;
            in_op = v_op[i]; in_a = v_a[i]; in_b = v_b[i];
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL arith_latency[%0d]: got out_valid %b required 0", i, out_valid);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== v_r[i] || {out_c, out_n, out_z, out_v} !== v_f[i]) begin
                fails++;
                $display("[TB] FAIL arith[%0d]: got v%b res %h cnzv %b required v1 res %h cnzv %b", i,
                         out_valid, out_result, {out_c, out_n, out_z, out_v}, v_r[i], v_f[i]);
            end
            checks++;
            if (ops_done !== 8'(i + 1)) begin
                fails++;
                $display("[TB] FAIL arith_count[%0d]: got %0d required %0d", i, ops_done, i + 1);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL arith_drain: got out_valid %b required 0", out_valid);
        end
    endtask

    task automatic test_logic();
        logic [2:0] v_op [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b010};
        logic [3:0] v_a  [7] = '{4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC};
        logic [3:0] v_b  [7] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h3};
        logic [3:0] v_r  [7] = '{4'h3, 4'h5, 4'h8, 4'hE, 4'h6, 4'h9, 4'h0};
        logic [3:0] v_f  [7] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_acc = 1'b0;
            in_op = v_op[i]; in_a = v_a[i]; in_b = v_b[i];
            step();
            in_valid = 1'b0;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== v_r[i] || {out_c, out_n, out_z, out_v} !== v_f[i]) begin
                fails++;
                $display("[TB] FAIL logic[%0d]: got v%b res %h cnzv %b required v1 res %h cnzv %b", i,
                         out_valid, out_result, {out_c, out_n, out_z, out_v}, v_r[i], v_f[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_r [3] = '{4'h3, 4'h6, 4'h9};
        do_reset();
        in_valid = 1'b1; in_acc = 1'b1; in_op = 3'b110; in_a = 4'hF; in_b = 4'h3;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_valid = 1'b0;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_r[i]) begin
                fails++;
                $display("[TB] FAIL acc_chain[%0d]: got v%b res %h required v1 res %h", i,
                         out_valid, out_result, exp_r[i]);
            end
        end
        checks++;
        if ({out_c, out_n, out_z, out_v} !== 4'b0101) begin
            fails++;
            $display("[TB] FAIL acc_chain_flags: got cnzv %b required 0101", {out_c, out_n, out_z, out_v});
        end
        in_valid = 1'b1; in_acc = 1'b1; in_op = 3'b110; in_a = 4'h0; in_b = 4'h0;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_result !== 4'h9) begin
            fails++;
            $display("[TB] FAIL acc_value: got %h required 9", out_result);
        end
        in_acc = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b110; in_a = 4'h1; in_b = 4'h1;
        step();
        in_a = 4'h2; in_b = 4'h2;
        step();
        in_a = 4'h3; in_b = 4'h3;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 4'h2) begin
            fails++;
            $display("[TB] FAIL bp_full: got ready %b valid %b res %h required 0 1 2",
                     in_ready, out_valid, out_result);
        end
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || out_result !== 4'h2 || ops_done !== 8'd1) begin
            fails++;
            $display("[TB] FAIL bp_hold: got ready %b res %h ops %0d required 0 2 1",
                     in_ready, out_result, ops_done);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_release_ready: got %b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 4'h4) begin
            fails++;
            $display("[TB] FAIL bp_second: got v%b res %h required v1 res 4", out_valid, out_result);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 4'h6) begin
            fails++;
            $display("[TB] FAIL bp_third: got v%b res %h required v1 res 6", out_valid, out_result);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || ops_done !== 8'd3) begin
            fails++;
            $display("[TB] FAIL bp_drain: got v%b ops %0d required v0 ops 3", out_valid, ops_done);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        in_valid = 1'b1; in_op = 3'b100; in_a = 4'h5; in_b = 4'hA;
        repeat (255) step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (ops_done !== 8'd255) begin
            fails++;
            $display("[TB] FAIL count_max: got %0d required 255", ops_done);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (ops_done !== 8'd0 || out_result !== 4'hF) begin
            fails++;
            $display("[TB] FAIL count_wrap: got ops %0d res %h required 0 F", ops_done, out_result);
        end
    endtask

`ifdef ALU4_STICKY_FLAGS_EN
    task automatic test_sticky();
        do_reset();
        sticky_clr = 1'b0;
        in_valid = 1'b1; in_op = 3'b110; in_a = 4'h7; in_b = 4'h1;
        step();
        in_a = 4'h1; in_b = 4'h1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({sticky_c, sticky_v} !== 2'b01 || out_result !== 4'h2) begin
            fails++;
            $display("[TB] FAIL sticky_hold: got cv %b res %h required 01 2", {sticky_c, sticky_v}, out_result);
        end
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++;
        if ({sticky_c, sticky_v} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL sticky_clear: got cv %b required 00", {sticky_c, sticky_v});
        end
        in_valid = 1'b1; in_op = 3'b111; in_a = 4'h5; in_b = 4'h5;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({sticky_c, sticky_v} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL sticky_carry: got cv %b required 10", {sticky_c, sticky_v});
        end
    endtask
`endif

    initial begin
`ifdef ALU4_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        test_reset();
        test_arith();
        test_logic();
        test_back_to_back();
        test_backpressure();
        test_count_wrap();
`ifdef ALU4_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
